tb_status_periph: RTL and testbench
===================================

TB_STATUS_PERIPH -- requirements
Module: tb_status_periph

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: stdout character FIFO depth; power of two, at least 2.
REQ-002 Parameter PASS_MAGIC, default 32'd123456789: STATUS write value that signals pass.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  1  data-bus request from the core.
REQ-006 we_i  input  1  1 = write, 0 = read.
REQ-007 addr_i  input  8  byte offset within the peripheral; bits [7:2] decode, bits [1:0] ignored.
REQ-008 be_i  input  4  byte enables.
REQ-009 wdata_i  input  32  write data.
REQ-010 gnt_o  output  1  request accepted this cycle.
REQ-011 rvalid_o  output  1  response valid.
REQ-012 rdata_o  output  32  read data; valid while rvalid_o is high.
REQ-013 char_valid_o  output  1  FIFO head character available.
REQ-014 char_o  output  8  FIFO head character.
REQ-015 char_ready_i  input  1  consumer accepts the head character.
REQ-016 tests_passed_o  output  1  sticky pass flag.
REQ-017 tests_failed_o  output  1  sticky fail flag.
REQ-018 exit_valid_o  output  1  sticky exit flag.
REQ-019 exit_value_o  output  32  exit code.

Function
REQ-020 Address map:
- 0x00 PRINT: write-only; wdata_i[7:0] is pushed into the FIFO when be_i[0]=1.
- 0x04 STATUS: write-only.
- 0x08 EXIT: write-only.
- 0x0C CYCLE: read-only; see Configuration.
- 0x10 LEVEL: read-only; FIFO occupancy, zero-extended.
- Any other offset is unmapped.
REQ-021 Grant rule: gnt_o = req_i AND NOT(we_i AND offset==PRINT AND FIFO full); gnt_o is combinational.
- No other stall source exists.
REQ-022 Response timing: rvalid_o is asserted exactly one cycle after each granted request, for one cycle.
- Back-to-back grants produce back-to-back rvalid pulses.
REQ-023 Read data: rdata_o is the register value sampled at grant; rdata_o is 0 for writes and for unmapped reads.
REQ-024 Writes to unmapped or read-only offsets, and reads of write-only offsets, are granted and have no side effect.
REQ-025 PRINT writes with be_i[0]=0 are granted and have no effect.
REQ-026 FIFO:
- Circular buffer with wrapping read and write pointers.
- Occupancy counter width is clog2(FIFO_DEPTH)+1.
- char_valid_o = occupancy != 0.
- Pop occurs when char_valid_o AND char_ready_i.
REQ-027 Simultaneous push and pop:
- Non-full FIFO: occupancy unchanged, both pointers advance.
- Full FIFO: push is stalled by REQ-021 and the pop proceeds.
REQ-028 A push into an empty FIFO makes char_valid_o high on the next cycle; there is no fall-through.
REQ-029 STATUS write, applied the cycle after grant:
- wdata_i == PASS_MAGIC sets tests_passed_o.
- Any other value sets tests_failed_o.
REQ-030 EXIT write, applied the cycle after grant:
- exit_value_o <= wdata_i.
- exit_valid_o <= 1.
REQ-031 Flags:
- tests_passed_o, tests_failed_o and exit_valid_o remain set until reset.
- Later writes may set the other flag; both flags may be high together.
- A later EXIT write updates exit_value_o.

Reset
REQ-032 Assertion of rst_n, including mid-transfer, immediately clears all state:
- gnt_o is combinational and follows REQ-021 on the reset-state FIFO.
- rvalid_o=0 and rdata_o=0.
- FIFO is emptied: char_valid_o=0, char_o=0.
- All flags=0 and exit_value_o=0.
- Cycle counter=0.
- Pending responses are dropped.

Configuration
REQ-033 Macro TB_STATUS_CYCLE_CNT_EN:
- Defined: a 32-bit counter increments every cycle after reset, wraps at 2^32-1 to 0, and CYCLE reads return the counter value sampled at grant.
- Undefined: no counter exists and CYCLE behaves as an unmapped offset (reads return 0).

Verification
REQ-034 Write PRINT 0x41, 0x42 with char_ready_i=1 -> char_o shows 0x41 then 0x42, one char_valid_o cycle each, each starting the cycle after the corresponding grant.
REQ-035 char_ready_i=0, 9 PRINT writes with FIFO_DEPTH=8 -> first 8 granted, LEVEL reads 8, 9th has gnt_o=0; raise char_ready_i -> 9th granted next cycle.
REQ-036 STATUS write 123456789 -> tests_passed_o=1 next cycle; STATUS write 5 -> tests_failed_o=1 and tests_passed_o stays 1.
REQ-037 EXIT write 0x0000002A -> exit_valid_o=1 and exit_value_o=42 one cycle after grant, rvalid_o pulse with rdata_o=0.
REQ-038 With TB_STATUS_CYCLE_CNT_EN defined, two CYCLE reads granted 10 cycles apart -> values differ by 10; undefined -> both read 0.
REQ-039 rst_n low while FIFO holds 3 chars and an EXIT write is granted -> char_valid_o=0, exit_valid_o=0, no rvalid_o after reset release.

Source files
------------

// File: rtl/tb_status_periph.sv
// tb_status_periph: testbench status peripheral with stdout FIFO, pass/fail flags and exit code.
// Optional macro TB_STATUS_CYCLE_CNT_EN adds a free-running 32-bit cycle counter readable at CYCLE.
module tb_status_periph #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [5:0]  OFF_PRINT = 6'd0;
    localparam logic [5:0]  OFF_STAT  = 6'd1;
    localparam logic [5:0]  OFF_EXIT  = 6'd2;
    localparam logic [5:0]  OFF_CYCLE = 6'd3;
    localparam logic [5:0]  OFF_LEVEL = 6'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [5:0]    off;
    logic          full, wr, rd, push, pop;
    logic [31:0]   cyc_val, rd_val;
    logic          unused_bits;

    assign unused_bits  = ^{addr_i[1:0], be_i[3:1]};
    assign off          = addr_i[7:2];
    assign full         = level == FULL_LVL;
    assign gnt_o        = req_i & ~(we_i & (off == OFF_PRINT) & full);
    assign wr           = gnt_o & we_i;
    assign rd           = gnt_o & ~we_i;
    assign push         = wr & (off == OFF_PRINT) & be_i[0];
    assign char_valid_o = level != '0;
    assign pop          = char_valid_o & char_ready_i;
    assign char_o       = char_valid_o ? mem[rd_ptr] : 8'h00;

`ifdef TB_STATUS_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;

    // Free-running cycle counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_cnt <= '0;
        else        cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign cyc_val = cycle_cnt;
`else
    assign cyc_val = '0;
`endif

    // Read value captured at grant; writes and unmapped reads return zero
    always_comb begin
        rd_val = '0;
        if (rd) rd_val = (off == OFF_CYCLE) ? cyc_val :
                         (off == OFF_LEVEL) ? 32'(level) : 32'd0;
    end

    // Character storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata_i[7:0];
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Response pipeline and sticky status/exit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_o       <= 1'b0;
            rdata_o        <= '0;
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else begin
            rvalid_o <= gnt_o;
            rdata_o  <= rd_val;
            if (wr && off == OFF_STAT) begin
                if (wdata_i == PASS_MAGIC) tests_passed_o <= 1'b1;
                else                       tests_failed_o <= 1'b1;
            end
            if (wr && off == OFF_EXIT) begin
                exit_valid_o <= 1'b1;
                exit_value_o <= wdata_i;
            end
        end
    end
endmodule

// File: tb/tb_tb_status_periph.sv
// tb_tb_status_periph: directed plus random checks of tb_status_periph against a queue-based model.
module tb_tb_status_periph;
    localparam int          DEPTH = 8;
    localparam logic [31:0] MAGIC = 32'd123456789;
`ifdef TB_STATUS_CYCLE_CNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, char_ready = 1'b0;
    logic [7:0]  addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        gnt, rvalid, char_valid, passed_f, failed_f, exit_valid;
    logic [31:0] rdata, exit_value;
    logic [7:0]  char_o;

    logic [7:0]  q[$];
    logic        pass_m, fail_m, exit_v_m;
    logic [31:0] exit_val_m;
    int unsigned cyc_m;
    int          total = 0;
    int          passed = 0;

    tb_status_periph #(.FIFO_DEPTH(DEPTH), .PASS_MAGIC(MAGIC)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .char_valid_o(char_valid), .char_o(char_o), .char_ready_i(char_ready),
        .tests_passed_o(passed_f), .tests_failed_o(failed_f),
        .exit_valid_o(exit_valid), .exit_value_o(exit_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_flags();
        chk("tests_passed", passed_f, pass_m);
        chk("tests_failed", failed_f, fail_m);
        chk("exit_valid", exit_valid, exit_v_m);
        chk("exit_value", exit_value, exit_val_m);
    endtask

    // Asserts reset mid-cycle, checks the cleared state, releases just after a rising edge
    task automatic do_reset();
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; char_ready = 1'b0;
        #1;
        q.delete();
        pass_m = 0; fail_m = 0; exit_v_m = 0; exit_val_m = 0; cyc_m = 0;
        chk("rst_gnt_idle", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_char", char_o, 0);
        chk_flags();
        req = 1'b1; we = 1'b1; addr = 8'h00;
        #1;
        chk("rst_gnt_print", gnt, 1);
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One bus cycle; called just after a rising edge, returns just after the next one
    task automatic step(input logic rq, input logic w, input logic [7:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic rdy);
        logic        eg, dpop;
        logic [31:0] er;
        logic [5:0]  o;
        o = a[7:2];
        req = rq; we = w; addr = a; be = b; wdata = d; char_ready = rdy;
        #4;
        eg = rq && !(w && o == 0 && q.size() == DEPTH);
        chk("gnt", gnt, eg);
        chk("char_valid", char_valid, q.size() != 0);
        chk("char", char_o, q.size() != 0 ? q[0] : 8'h00);
        er = 0;
        if (eg && !w && o == 3) er = CYC_EN ? cyc_m : 0;
        if (eg && !w && o == 4) er = q.size();
        dpop = q.size() != 0 && rdy;
        @(posedge clk);
        #1;
        cyc_m++;
        if (dpop) void'(q.pop_front());
        if (eg && w && o == 0 && b[0]) q.push_back(d[7:0]);
        if (eg && w && o == 1) begin
            if (d == MAGIC) pass_m = 1;
            else fail_m = 1;
        end
        if (eg && w && o == 2) begin
            exit_v_m = 1;
            exit_val_m = d;
        end
        req = 1'b0;
        chk("rvalid", rvalid, eg);
        chk("rdata", rdata, er);
        chk_flags();
    endtask

    initial begin
        logic [5:0]  o;
        logic [31:0] d;
        do_reset();
        step(1, 1, 8'h00, 4'h1, 32'h41, 1);
        step(1, 1, 8'h00, 4'h1, 32'h42, 1);
        step(0, 0, 8'h00, 4'h0, 0, 1);
        step(0, 0, 8'h00, 4'h0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 8'h00, 4'hF, 32'h60 + i, 0);
        step(1, 0, 8'h10, 4'hF, 0, 0);
        step(1, 1, 8'h03, 4'h1, 32'h68, 0);
        step(1, 1, 8'h00, 4'h1, 32'h68, 1);
        step(1, 1, 8'h00, 4'h1, 32'h68, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 4'h0, 0, 1);
        step(1, 1, 8'h00, 4'hE, 32'h77, 1);
        step(1, 1, 8'h04, 4'hF, MAGIC, 1);
        step(1, 1, 8'h04, 4'hF, 32'd5, 1);
        step(1, 1, 8'h08, 4'hF, 32'h2A, 1);
        step(1, 0, 8'h0C, 4'hF, 0, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 4'h0, 0, 1);
        step(1, 0, 8'h0C, 4'hF, 0, 1);
        step(1, 0, 8'h00, 4'hF, 0, 1);
        step(1, 0, 8'h14, 4'hF, 0, 1);
        step(1, 1, 8'h10, 4'hF, 32'h99, 1);
        step(1, 1, 8'hFC, 4'hF, 32'h99, 1);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            o = 6'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) o = 6'h3F;
            d = ($urandom_range(0, 3) == 0) ? MAGIC : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, {o, 2'($urandom)},
                 4'($urandom), d, $urandom_range(0, 2) == 0);
        end
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 8'h00, 4'h1, 32'h30 + i, 0);
        step(1, 1, 8'h08, 4'hF, 32'h55, 0);
        do_reset();
        step(0, 0, 8'h00, 4'h0, 0, 0);
        step(0, 0, 8'h00, 4'h0, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
